// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative 1-bit-per-cycle shifter for the execute stage.
// It decodes R-type shifts (SLL/SRL/SRA and their variable forms), sequences
// the shift across IDLE -> SHIFT -> DONE, and tells the ALU B-operand mux to
// pick the shift result (code 2'b11) during the DONE cycle.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [AMT_W-1:0] shamt,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             is_shift,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       sel_operaB1
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SRA    = 6'h03;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_SRLV   = 6'h06;
    localparam logic [5:0] F_SRAV   = 6'h07;

    localparam logic [1:0] SEL_SHIFT = 2'b11;
    localparam logic [1:0] SEL_NONE  = 2'b00;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data, data_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic             left, left_nx;
    logic             arith, arith_nx;

    logic             dec_left;
    logic             dec_arith;
    logic             dec_var;
    logic [AMT_W-1:0] amount;
    logic             accept;
    logic [WIDTH-1:0] data_step;

    // Only the low AMT_W bits of rs select the amount; the rest are don't-care.
    logic             rs_hi_unused;
    assign rs_hi_unused = ^rs_val[WIDTH-1:AMT_W];

    // Instruction decode: which shift, which direction, where the amount comes from.
    always_comb begin
        is_shift  = 1'b0;
        dec_left  = 1'b0;
        dec_arith = 1'b0;
        dec_var   = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_SLL:  begin is_shift = 1'b1; dec_left = 1'b1; end
                F_SRL:  begin is_shift = 1'b1; end
                F_SRA:  begin is_shift = 1'b1; dec_arith = 1'b1; end
                F_SLLV: begin is_shift = 1'b1; dec_left = 1'b1; dec_var = 1'b1; end
                F_SRLV: begin is_shift = 1'b1; dec_var = 1'b1; end
                F_SRAV: begin is_shift = 1'b1; dec_arith = 1'b1; dec_var = 1'b1; end
                default: ;
            endcase
        end
    end

    assign amount = dec_var ? rs_val[AMT_W-1:0] : shamt;

    // A new op may issue from IDLE or straight out of DONE; SHIFT ignores start.
    assign accept = start && is_shift && (state != SHIFT);

    // One shift step. In the arithmetic case data[WIDTH-1] still holds the
    // captured sign, since every previous step re-filled it with itself.
    always_comb begin
        if (left)
            data_step = {data[WIDTH-2:0], 1'b0};
        else
            data_step = {arith & data[WIDTH-1], data[WIDTH-1:1]};
    end

    // Next-state and datapath-update logic.
    always_comb begin
        state_nx = state;
        data_nx  = data;
        cnt_nx   = cnt;
        left_nx  = left;
        arith_nx = arith;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    data_nx  = rt_val;
                    cnt_nx   = amount;
                    left_nx  = dec_left;
                    arith_nx = dec_arith;
                    state_nx = (amount == '0) ? DONE : SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                data_nx = data_step;
                cnt_nx  = cnt - 1'b1;
                if (cnt == AMT_W'(1))
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            left  <= 1'b0;
            arith <= 1'b0;
        end else begin
            state <= state_nx;
            data  <= data_nx;
            cnt   <= cnt_nx;
            left  <= left_nx;
            arith <= arith_nx;
        end
    end

    // Mux select is registered so it lines up exactly with the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_operaB1 <= SEL_NONE;
        else
            sel_operaB1 <= (state_nx == DONE) ? SEL_SHIFT : SEL_NONE;
    end

    assign busy   = (state == SHIFT) || (state == DONE);
    assign stall  = (state == SHIFT);
    assign done   = (state == DONE);
    assign result = data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a vector table of shifts with
// expected results/latencies, a result scoreboard, and hand-written
// sequences for ignored starts, mid-shift reset and back-to-back issue.
module tb_shift_sequencer;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    logic             clk, rst, start;
    logic [5:0]       opcode, funct;
    logic [AMT_W-1:0] shamt;
    logic [WIDTH-1:0] rs_val, rt_val;
    logic             is_shift, busy, stall, done;
    logic [WIDTH-1:0] result;
    logic [1:0]       sel_operaB1;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_res;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
        .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .is_shift(is_shift),
        .busy(busy), .stall(stall), .done(done), .result(result),
        .sel_operaB1(sel_operaB1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt);
        opcode = 6'h00; funct = f; shamt = sa; rs_val = rs; rt_val = rt; start = 1'b1;
    endtask

    // Called at the negedge just after the accepting edge. Waits for done,
    // checking latency, stall count, select code and the scoreboard result.
    task automatic wait_done(input string name, input int lat);
        int cyc = 0;
        int stalls = 0;
        logic [31:0] exp;
        while (!done && cyc < 200) begin
            if (stall) stalls++;
            check({name, "_sel_idle"}, {30'd0, sel_operaB1}, 32'd0);
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
            return;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({name, "_result"}, result, exp);
        check({name, "_latency"}, cyc, lat);
        check({name, "_stalls"}, stalls, lat);
        check({name, "_sel_done"}, {30'd0, sel_operaB1}, 32'd3);
        check({name, "_busy_done"}, {31'd0, busy}, 32'd1);
        last_res = exp;
    endtask

    // After a lone done, the next cycle is IDLE with result held.
    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({name, "_sel_after"}, {30'd0, sel_operaB1}, 32'd0);
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({name, "_hold"}, result, last_res);
    endtask

    initial begin
        vecs[0] = '{"sll4",    6'h00, 5'd4,  32'h0,        32'h0000000F, 32'h000000F0, 4};
        vecs[1] = '{"sra8",    6'h03, 5'd8,  32'h0,        32'h80000000, 32'hFF800000, 8};
        vecs[2] = '{"srl8",    6'h02, 5'd8,  32'h0,        32'h80000000, 32'h00800000, 8};
        vecs[3] = '{"srlv3",   6'h06, 5'd0,  32'h00000023, 32'h000000F0, 32'h0000001E, 3};
        vecs[4] = '{"sll0",    6'h00, 5'd0,  32'h0,        32'h12345678, 32'h12345678, 0};
        vecs[5] = '{"srav31",  6'h07, 5'd9,  32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 31};
        vecs[6] = '{"sllv1",   6'h04, 5'd7,  32'hFFFFFFE1, 32'h40000001, 32'h80000002, 1};
        vecs[7] = '{"sra4pos", 6'h03, 5'd4,  32'h0,        32'h70000000, 32'h07000000, 4};
        vecs[8] = '{"srlv0",   6'h06, 5'd3,  32'h00000020, 32'h0000ABCD, 32'h0000ABCD, 0};

        rst = 1'b1; start = 1'b0; opcode = 6'h00; funct = 6'h00; shamt = '0;
        rs_val = '0; rt_val = '0; last_res = '0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sel", {30'd0, sel_operaB1}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].funct, vecs[i].shamt, vecs[i].rs, vecs[i].rt);
            exp_q.push_back(vecs[i].exp);
            #1 check({vecs[i].name, "_is_shift"}, {31'd0, is_shift}, 32'd1);
            @(negedge clk);
            start = 1'b0;
            wait_done(vecs[i].name, vecs[i].lat);
            check_idle(vecs[i].name);
        end

        // Unsupported funct: start is ignored, nothing moves
        drive(6'h20, 5'd4, 32'h0, 32'hCAFEF00D);
        #1 check("bad_is_shift", {31'd0, is_shift}, 32'd0);
        @(negedge clk);
        check("bad_busy", {31'd0, busy}, 32'd0);
        check("bad_result", result, last_res);
        @(negedge clk);
        check("bad_done", {31'd0, done}, 32'd0);
        start = 1'b0;

        // start re-asserted mid-SHIFT with different operands is ignored
        drive(6'h00, 5'd4, 32'h0, 32'h0000000F);
        exp_q.push_back(32'h000000F0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        drive(6'h02, 5'd1, 32'h0, 32'hFFFF0000);
        @(negedge clk); start = 1'b0;
        wait_done("midshift", 2);
        check_idle("midshift");

        // Reset on cycle 2 of a 10-bit shift clears outputs immediately
        drive(6'h00, 5'd10, 32'h0, 32'h00000001);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_sel", {30'd0, sel_operaB1}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First op after reset, then a back-to-back issue held from DONE
        drive(6'h00, 5'd1, 32'h0, 32'h00000001);
        exp_q.push_back(32'h00000002);
        @(negedge clk); start = 1'b0;
        wait_done("post_rst", 1);
        drive(6'h00, 5'd2, 32'h0, 32'h00000003);
        exp_q.push_back(32'h0000000C);
        @(negedge clk); start = 1'b0;
        check("b2b_no_gap", {31'd0, stall}, 32'd1);
        wait_done("b2b", 2);
        check_idle("b2b");

        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
